// File: rtl/trig_capture.sv
// Triggered capture buffer: records a DEPTH-sample window around a trigger rising edge
// (PRE samples of history) and streams it out as a header plus byte pairs over valid/ready.
module trig_capture #(
    parameter int DEPTH = 256,
    parameter int PRE   = 32
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [13:0] ADC_IN,
    input  logic        trigger,
    input  logic        arm,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam int AW     = $clog2(DEPTH);
    localparam int NBYTES = 2 + 2 * DEPTH;
    localparam int NBW    = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_ARMED,
        S_POST,
        S_READOUT
    } state_t;

    state_t          state_q, state_d;
    logic [13:0]     mem [DEPTH];
    logic [13:0]     rd_q;
    logic [AW-1:0]   wp, start, rd_addr, cnt;
    logic [NBW-1:0]  nb;
    logic [7:0]      lo_byte, byte_next;
    logic            trig_d, trig_edge, wr_en, load, is_hi, last_xfer;

    assign trig_edge = trigger & ~trig_d;
    assign busy      = (state_q != S_IDLE);
    assign load      = (state_q == S_READOUT) && (!tx_valid || tx_ready) && (nb != NBW'(NBYTES));
    assign last_xfer = (state_q == S_READOUT) && tx_valid && tx_ready && (nb == NBW'(NBYTES));

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_PRETRIG;
            end
            S_PRETRIG: begin
                wr_en = 1'b1;
                if (cnt == AW'(PRE - 1)) state_d = S_ARMED;
            end
            S_ARMED: begin
                wr_en = 1'b1;
                if (trig_edge) state_d = S_POST;
            end
            S_POST: begin
                wr_en = 1'b1;
                if (cnt == AW'(DEPTH - PRE - 2)) state_d = S_READOUT;
            end
            S_READOUT: begin
                if (last_xfer) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Even byte indices from 2 up carry the high half of the sample waiting in rd_q.
    always_comb begin
        is_hi     = 1'b0;
        byte_next = lo_byte;
        if (nb == NBW'(0)) begin
            byte_next = 8'hA5;
        end else if (nb == NBW'(1)) begin
            byte_next = 8'h5A;
        end else if (!nb[0]) begin
            is_hi     = 1'b1;
            byte_next = {2'b00, rd_q[13:8]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wp       <= '0;
            trig_d   <= 1'b0;
            cnt      <= '0;
            start    <= '0;
            rd_addr  <= '0;
            nb       <= '0;
            lo_byte  <= 8'h00;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            trig_d <= trigger;
            done   <= last_xfer;

            if (wr_en) wp <= wp + 1'b1;

            if (state_d != state_q) cnt <= '0;
            else if (wr_en)         cnt <= cnt + 1'b1;

            if (state_q == S_ARMED && trig_edge) start <= wp - AW'(PRE);

            // After the last post-trigger write wp has come round to start again.
            if (state_q == S_POST && state_d == S_READOUT) rd_addr <= start;
            else if (load && is_hi)                         rd_addr <= rd_addr + 1'b1;

            if (state_q != S_READOUT) nb <= '0;
            else if (load)            nb <= nb + 1'b1;

            if (load) begin
                tx_valid <= 1'b1;
                tx_data  <= byte_next;
                if (is_hi) lo_byte <= rd_q[7:0];
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

    // NOTE: the sample RAM has no reset; contents are only read after being written in the same capture.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem[wp] <= ADC_IN;
        rd_q <= mem[rd_addr];
    end

endmodule

// File: tb/tb_trig_capture.sv
// Scoreboard bench for trig_capture: stimulus pushes the expected byte stream, a
// negedge monitor pops and compares every accepted byte, stall stability and done timing.
module tb_trig_capture;

    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] adc;
    logic        trigger = 1'b0;
    logic        arm = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        done;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_xfer = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_q[$];
    bit          bp_mode = 1'b0;
    logic        ready_req = 1'b1;
    logic [7:0]  lfsr = 8'hA7;
    logic        stall_prev = 1'b0;
    logic        final_prev = 1'b0;
    logic [7:0]  stall_data = 8'h00;

    assign adc = 14'(cyc);

    trig_capture #(.DEPTH(DEPTH), .PRE(PRE)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .ADC_IN   (adc),
        .trigger  (trigger),
        .arm      (arm),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (bp_mode) begin
            lfsr     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            tx_ready = lfsr[0];
        end else begin
            tx_ready = ready_req;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (reset) begin
            stall_prev = 1'b0;
            final_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(stall_data));
            end
            if (done || final_prev) begin
                check("done_pulse", 32'(done), 32'(final_prev));
                if (final_prev) check("busy_after_done", 32'(busy), 32'd0);
            end
            if (done) done_cnt++;
            final_prev = 1'b0;
            if (tx_valid && tx_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_byte: got 0x%0h expected no byte at t=%0t", tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_byte", 32'(tx_data), 32'(e));
                    final_prev = (exp_q.size() == 0);
                end
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_adc(input int v);
        int n = 0;
        do begin
            step();
            n++;
        end while (int'(adc) != v && n < 20000);
        if (int'(adc) != v) check("wait_adc_timeout", 32'(adc), 32'(v));
    endtask

    task automatic arm_at(input int a);
        wait_adc(a);
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic set_trig(input int v, input logic lvl);
        wait_adc(v);
        trigger = lvl;
    endtask

    task automatic push_window(input int t);
        logic [13:0] s;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int k = 0; k < DEPTH; k++) begin
            s = 14'(t - PRE + k);
            exp_q.push_back({2'b00, s[13:8]});
            exp_q.push_back(s[7:0]);
        end
    endtask

    task automatic trig_at(input int t);
        wait_adc(t);
        trigger = 1'b1;
        push_window(t);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic wait_bytes(input int target);
        int n = 0;
        while (n_xfer < target && n < 400) begin
            step();
            n++;
        end
        check("byte_count_reached", 32'(n_xfer >= target), 32'd1);
    endtask

    initial begin
        int base;
        int d0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        step();
        reset = 1'b0;

        // Basic capture: window 96..111
        arm_at(80);
        step();
        check("busy_after_arm", 32'(busy), 32'd1);
        trig_at(100);
        wait_done("s1_done", 200);

        // Edge gating: trigger already high on arm, drop at 200, rise at 205
        arm_at(190);
        set_trig(200, 1'b0);
        trig_at(205);
        wait_done("s2_done", 200);

        // Backpressure with pseudo-random tx_ready
        set_trig(280, 1'b0);
        bp_mode = 1'b1;
        arm_at(300);
        trig_at(320);
        wait_done("s3_done", 400);
        bp_mode = 1'b0;

        // Wrap-around: 37 cycles in ARMED before the edge
        set_trig(480, 1'b0);
        arm_at(500);
        trig_at(500 + PRE + 1 + 37);
        wait_done("s4_done", 200);

        // Ignored inputs: trigger rise in PRETRIG, arm during READOUT
        set_trig(680, 1'b0);
        arm_at(700);
        set_trig(702, 1'b1);
        set_trig(708, 1'b0);
        trig_at(715);
        wait_bytes(n_xfer + 5);
        arm = 1'b1;
        step();
        arm = 1'b0;
        wait_done("s5_done", 200);
        repeat (10) step();
        check("s5_no_restart_busy", 32'(busy), 32'd0);
        check("s5_no_restart_valid", 32'(tx_valid), 32'd0);

        // Reset mid-readout after byte 10, then a clean capture
        set_trig(780, 1'b0);
        arm_at(800);
        trig_at(820);
        base = n_xfer;
        wait_bytes(base + 10);
        reset     = 1'b1;
        ready_req = 1'b0;
        d0        = done_cnt;
        step();
        reset     = 1'b0;
        ready_req = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("s6_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_done", 32'(done), 32'd0);
        repeat (5) step();
        check("s6_no_done_after_reset", 32'(done_cnt - d0), 32'd0);
        set_trig(880, 1'b0);
        arm_at(900);
        trig_at(920);
        wait_done("s6_recapture_done", 200);

        repeat (3) step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
